// File: rtl/comar_sched_pkg.sv
// Shared constants for the COMAR AND gadget scheduler: LFSR shape, sequencer states, id sizing.
package comar_sched_pkg;

  localparam int unsigned LfsrWidth = 31;
  // x^31 + x^28 + 1 with the newest bit shifted in at bit 0
  localparam int unsigned LfsrTapHi = 30;
  localparam int unsigned LfsrTapLo = 27;
  localparam int unsigned LfsrSteps = 6;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t StRun   = 2'd0;
  localparam sched_state_t StDrain = 2'd1;
  localparam sched_state_t StSwap  = 2'd2;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comar_lfsr6.sv
// 31-bit Fibonacci LFSR advanced six steps per cycle; a zero seed or reset value is replaced by 1.
module comar_lfsr6 import comar_sched_pkg::*; #(
  parameter logic [LfsrWidth-1:0] LFSR_SEED = 31'h1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seed_load,
  input  logic [LfsrWidth-1:0] seed,
  output logic [LfsrWidth-1:0] state
);

  localparam logic [LfsrWidth-1:0] ResetVal = (LFSR_SEED == '0) ? LfsrWidth'(1) : LFSR_SEED;

  logic [LfsrWidth-1:0] state_q, state_adv;

  always_comb begin
    state_adv = state_q;
    for (int unsigned i = 0; i < LfsrSteps; i++) begin
      state_adv = {state_adv[LfsrWidth-2:0], state_adv[LfsrTapHi] ^ state_adv[LfsrTapLo]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ResetVal;
    end else if (seed_load) begin
      state_q <= (seed == '0) ? LfsrWidth'(1) : seed;
    end else begin
      state_q <= state_adv;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/comar_and_sched.sv
// Round-robin sequencer for one shared COMAR AND gadget: issues ops, supplies fresh masks,
// tracks the 2-cycle gadget latency and swaps the common output mask after draining.
module comar_and_sched import comar_sched_pkg::*; #(
  parameter int unsigned          NUM_REQ   = 4,
  parameter int unsigned          OPT       = 0,
  parameter logic [LfsrWidth-1:0] LFSR_SEED = 31'h1,
  localparam int unsigned         IdW       = id_width(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   seed_load,
  input  logic [LfsrWidth-1:0]   seed,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [2*NUM_REQ-1:0]   req_a,
  input  logic [2*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   remask_req,
  output logic                   remask_done,
  output logic [1:0]             g_a,
  output logic [1:0]             g_b,
  output logic [5:0]             g_r,
  output logic                   g_common_out,
  input  logic [1:0]             g_c,
  output logic                   rsp_valid,
  output logic [IdW-1:0]         rsp_id,
  output logic [1:0]             rsp_c
);

  logic [LfsrWidth-1:0] lfsr;
  sched_state_t         state_q, state_d;
  logic [IdW-1:0]       rr_q, rr_d, s1_id_q, s2_id_q, win_id;
  logic                 s1_valid_q, s2_valid_q, issued_q, cm_q;
  logic [1:0]           a_hold_q, b_hold_q;
  logic                 issue_ok, grant;
  logic [31:0]          cand;
  logic [NUM_REQ-1:0]   vsh;
  logic [2*NUM_REQ-1:0] a_sh, b_sh;

  comar_lfsr6 #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .state     (lfsr)
  );

  // OPT=1 keeps share 1 unregistered in the gadget, so it needs a free cycle after each issue
  assign issue_ok = rst_n && (state_q == StRun) && !remask_req && !((OPT != 0) && issued_q);

  always_comb begin
    grant  = 1'b0;
    win_id = '0;
    cand   = '0;
    vsh    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(rr_q) + k) % NUM_REQ;
      vsh  = req_valid >> cand;
      if (issue_ok && !grant && vsh[0]) begin
        grant  = 1'b1;
        win_id = cand[IdW-1:0];
      end
    end
  end

  assign req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;
  assign rr_d      = (win_id == IdW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
  assign a_sh      = req_a >> {win_id, 1'b0};
  assign b_sh      = req_b >> {win_id, 1'b0};

  always_comb begin
    if (grant) begin
      g_a = a_sh[1:0];
      g_b = b_sh[1:0];
    end else if ((OPT != 0) && rst_n) begin
      g_a = a_hold_q;
      g_b = b_hold_q;
    end else begin
      g_a = 2'b00;
      g_b = 2'b00;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (remask_req) state_d = StDrain;
      // Nothing issues while draining, so an op in s2 retires this very cycle
      StDrain: if (!s1_valid_q) state_d = StSwap;
      StSwap:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StRun;
      cm_q       <= 1'b0;
      rr_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s2_id_q    <= '0;
      issued_q   <= 1'b0;
      a_hold_q   <= 2'b00;
      b_hold_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= grant;
      s1_id_q    <= win_id;
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
      issued_q   <= grant;
      if (grant) begin
        rr_q     <= rr_d;
        a_hold_q <= g_a;
        b_hold_q <= g_b;
      end
      if (state_q == StSwap) cm_q <= lfsr[LfsrSteps];
    end
  end

  assign g_r          = lfsr[5:0];
  assign g_common_out = cm_q;
  assign remask_done  = rst_n && (state_q == StSwap);
  assign rsp_valid    = rst_n && s2_valid_q;
  assign rsp_id       = s2_id_q;
  assign rsp_c        = g_c;

endmodule

// File: tb/tb_comar_and_sched.sv
// Bench for comar_and_sched: directed vector table, OPT=1 pacing, seed handling and random
// traffic against a queue-based reference model.
module tb_comar_and_sched;

  localparam logic [30:0] SEED0 = 31'h2545_F491;

  logic        clk = 1'b0;
  logic        rst_n, seed_load, remask_req;
  logic [30:0] seed;
  logic [3:0]  req_valid, req_valid1, req_ready, req_ready1;
  logic [7:0]  req_a, req_b;
  logic        remask_done, remask_done1, g_common_out, gco1, rsp_valid, rsp_valid1;
  logic [1:0]  g_a, g_b, g_a1, g_b1, g_c, rsp_id, rsp_id1, rsp_c, rsp_c1;
  logic [5:0]  g_r, g_r1;

  always #5 clk = ~clk;

  comar_and_sched #(.NUM_REQ(4), .OPT(0), .LFSR_SEED(SEED0)) dut0 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .remask_req(remask_req),
    .remask_done(remask_done), .g_a(g_a), .g_b(g_b), .g_r(g_r), .g_common_out(g_common_out),
    .g_c(g_c), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_c(rsp_c)
  );

  comar_and_sched #(.NUM_REQ(4), .OPT(1), .LFSR_SEED(31'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .seed_load(1'b0), .seed(31'h0), .req_valid(req_valid1),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready1), .remask_req(1'b0),
    .remask_done(remask_done1), .g_a(g_a1), .g_b(g_b1), .g_r(g_r1), .g_common_out(gco1),
    .g_c(g_c), .rsp_valid(rsp_valid1), .rsp_id(rsp_id1), .rsp_c(rsp_c1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: LFSR as a bit history (newest at back), in-flight ops as a due-time queue
  typedef struct { int due; int id; } pend_t;
  bit    m_hist[$];
  pend_t m_pend[$];
  int    m_rr, m_mode, cyc;  // m_mode: 0 normal, 1 waiting for drain, 2 swapping
  bit    m_cm, synced, e_grant;
  int    e_win;

  function automatic bit m_bit(input int i);
    return m_hist[m_hist.size() - 1 - i];
  endfunction

  task automatic m_load(input logic [30:0] v);
    m_hist.delete();
    for (int i = 30; i >= 0; i--) m_hist.push_back(v[i]);
  endtask

  task automatic m_shift();
    bit nb;
    nb = m_bit(30) ^ m_bit(27);
    m_hist.push_back(nb);
    void'(m_hist.pop_front());
  endtask

  task automatic m_check();
    bit         rv;
    int         rid;
    logic [5:0] er;
    logic [7:0] sa, sb;
    e_grant = 1'b0;
    e_win   = 0;
    if (m_mode == 0 && !remask_req) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_rr + k) % 4;
        if (!e_grant && req_valid[idx]) begin
          e_grant = 1'b1;
          e_win   = idx;
        end
      end
    end
    rv  = 1'b0;
    rid = 0;
    foreach (m_pend[j]) if (m_pend[j].due == cyc) begin rv = 1'b1; rid = m_pend[j].id; end
    for (int i = 0; i < 6; i++) er[i] = m_bit(i);
    sa = req_a >> (2 * e_win);
    sb = req_b >> (2 * e_win);
    chk("m_ready", req_ready, e_grant ? (32'd1 << e_win) : 32'd0);
    chk("m_g_a", g_a, e_grant ? sa[1:0] : 2'b00);
    chk("m_g_b", g_b, e_grant ? sb[1:0] : 2'b00);
    chk("m_rsp_valid", rsp_valid, rv);
    if (rv) begin
      chk("m_rsp_id", rsp_id, rid);
      chk("m_rsp_c", rsp_c, g_c);
    end
    chk("m_remask_done", remask_done, m_mode == 2);
    chk("m_common_out", g_common_out, m_cm);
    chk("m_g_r", g_r, er);
  endtask

  task automatic m_update();
    if (!rst_n) begin
      m_load(SEED0);
      m_rr = 0; m_mode = 0; m_cm = 1'b0;
      m_pend.delete();
      synced = 1'b1;
    end else if (synced) begin
      while (m_pend.size() > 0 && m_pend[0].due <= cyc) void'(m_pend.pop_front());
      if (e_grant) begin
        m_pend.push_back('{cyc + 2, e_win});
        m_rr = (e_win + 1) % 4;
      end
      case (m_mode)
        0: if (remask_req) m_mode = 1;
        1: if (m_pend.size() == 0) m_mode = 2;
        default: begin m_cm = m_bit(6); m_mode = 0; end
      endcase
      if (seed_load) m_load((seed == 31'd0) ? 31'd1 : seed);
      else repeat (6) m_shift();
    end
    cyc++;
  endtask

  // Sample at the falling edge, commit the model at the rising edge
  task automatic half();
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_done", remask_done, 0);
      chk("rst_g_ab", {g_a, g_b}, 0);
      chk("rst_ready1", req_ready1, 0);
      chk("rst_g_a1", g_a1, 0);
      e_grant = 1'b0;
    end else if (synced) begin
      m_check();
    end
  endtask

  task automatic fin();
    @(posedge clk);
    m_update();
    #1;
  endtask

  typedef struct {
    bit rst; logic [3:0] valid; bit remask; logic [3:0] ready; bit rsp_v; int rsp_id; bit done;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit r, input logic [3:0] v, input bit rm, input logic [3:0] rd,
                     input bit rv, input int id, input bit dn);
    vec_t e;
    e.rst = r; e.valid = v; e.remask = rm; e.ready = rd; e.rsp_v = rv; e.rsp_id = id; e.done = dn;
    tv.push_back(e);
  endtask

  initial begin
    logic [3:0]  exp1;
    logic [1:0]  prev_a;
    logic [7:0]  sh;
    int          zrun, zmax;
    rst_n = 1'b0; seed_load = 1'b0; seed = '0; remask_req = 1'b0;
    req_valid = '0; req_valid1 = '0; req_a = '0; req_b = '0; g_c = '0;
    synced = 1'b0; cyc = 0; m_rr = 0; m_mode = 0; m_cm = 1'b0;

    // single op, then round robin with all requesters, remask drain, reset with op in flight
    add(1, 4'b0001, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 0, 4'b0001, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 4'b1111, 0, 4'(1 << (i % 4)), i >= 2, (i + 2) % 4, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 2, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 3, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 0, 4'b0001, 0, 0, 0);
    add(0, 4'b0001, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 0, 4'b0000, 1, 0, 0);
    add(0, 4'b0001, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b0001, 0, 4'b0001, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 0, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 0, 0, 0);

    foreach (tv[i]) begin
      rst_n = !tv[i].rst; req_valid = tv[i].valid; remask_req = tv[i].remask;
      req_a = 8'($urandom); req_b = 8'($urandom); g_c = 2'($urandom);
      half();
      chk($sformatf("tv%0d_ready", i), req_ready, tv[i].ready);
      chk($sformatf("tv%0d_rsp_valid", i), rsp_valid, tv[i].rsp_v);
      if (tv[i].rsp_v) chk($sformatf("tv%0d_rsp_id", i), rsp_id, tv[i].rsp_id);
      chk($sformatf("tv%0d_done", i), remask_done, tv[i].done);
      fin();
    end

    // OPT=1 instance: issue on alternate cycles, share 1 held through the following cycle
    rst_n = 1'b0; req_valid = '0; remask_req = 1'b0;
    half(); fin();
    rst_n = 1'b1; req_valid1 = 4'b0011; prev_a = '0;
    for (int i = 0; i < 8; i++) begin
      req_a = 8'($urandom); req_b = 8'($urandom);
      half();
      exp1 = (i % 2 == 1) ? 4'b0000 : ((i % 4 == 0) ? 4'b0001 : 4'b0010);
      chk($sformatf("opt1_ready%0d", i), req_ready1, exp1);
      if (i % 2 == 0) begin
        sh = req_a >> (2 * ((i % 4) / 2));
        chk($sformatf("opt1_g_a%0d", i), g_a1, sh[1:0]);
        prev_a = sh[1:0];
      end else begin
        chk($sformatf("opt1_hold%0d", i), g_a1[1], prev_a[1]);
      end
      fin();
    end
    req_valid1 = '0;

    // zero seed loads 1; then the LFSR must keep producing fresh bits
    seed_load = 1'b1; seed = '0;
    half(); fin();
    seed_load = 1'b0;
    half();
    chk("seed0_g_r", g_r, 6'b000001);
    fin();
    zrun = 0; zmax = 0;
    for (int i = 0; i < 100; i++) begin
      half();
      zrun = (g_r == 6'd0) ? zrun + 1 : 0;
      if (zrun > zmax) zmax = zrun;
      fin();
    end
    chk("g_r_zero_run_le5", zmax, (zmax <= 5) ? zmax : 5);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      req_valid  = 4'($urandom);
      remask_req = ($urandom_range(0, 9) == 0);
      seed_load  = ($urandom_range(0, 29) == 0);
      seed       = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
      req_a = 8'($urandom); req_b = 8'($urandom); g_c = 2'($urandom);
      half(); fin();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
